vga_vram_write_scheduler: RTL and testbench
===========================================

# vga_vram_write_scheduler

Single-clock controller that owns the write side of the 8-bit VGA VRAM (4096 cells, 64x64 blocks of 16x16 pixels). It shares the VRAM write port between two requesters with round-robin arbitration and runs a built-in fill engine that clears the whole VRAM, optionally deferred to vertical blanking. It also stages viewport offsets and commits them at frame boundaries, so scrolling never tears mid-frame. It sits in the `clk` domain between host logic and the VRAM's `data_*`, `offset_h/offset_v` and `vsync` ports.

## Interface
Parameters:
- C_ADDR_WIDTH, 12, VRAM address width
- C_VRAM_LENGTH, 4096, number of VRAM cells; fill range is 0..C_VRAM_LENGTH-1
- C_OFFSET_WIDTH, 10, width of staged offsets

Ports:
- clk  in  1  system clock, the only clock
- reset  in  1  synchronous, active-high
- vsync  in  1  active-low VGA vsync, already synchronized into `clk`
- req0_valid / req1_valid  in  1  write request
- req0_ready / req1_ready  out  1  grant, combinational
- req0_address / req1_address  in  C_ADDR_WIDTH  target cell
- req0_data / req1_data  in  8  pixel value
- fill_start  in  1  one-cycle pulse starting a fill
- fill_sync  in  1  sampled with fill_start: 1 = defer fill to next vblank
- fill_color  in  8  sampled with fill_start
- fill_busy  out  1  fill pending or running
- fill_done  out  1  one-cycle pulse after the last fill write
- offset_set  in  1  stage new offsets
- offset_h_in / offset_v_in  in  C_OFFSET_WIDTH  staged values
- data_address  out  32  to VRAM, zero-extended
- data_din  out  8  to VRAM
- data_we  out  1  to VRAM
- offset_h / offset_v  out  32  committed offsets, zero-extended
- frame_count  out  16  vblank counter

## Operation
- All outputs reset to 0. Internal state after reset: state IDLE, round-robin pointer favours req0, vsync history = 1, nothing pending.
- Vblank edge: `vs_edge = vsync_d & ~vsync`. `vsync_d` is a register of `vsync`.
- States:
  - IDLE: arbitrate requesters.
  - WAIT_VS: fill armed; requesters are still served.
  - FILL: engine owns the port and both readies are 0.
- Arbitration (IDLE and WAIT_VS):
  - A single valid requester is granted.
  - If both are valid, the requester not granted last wins. The pointer updates only on an accepted transfer.
  - Accept means `valid & ready`. An accept registers address/data and sets `data_we` for exactly one cycle.
- fill_start in IDLE:
  - `fill_sync = 0` -> FILL on the next cycle.
  - `fill_sync = 1` -> WAIT_VS.
  - `fill_busy` goes to 1 on the next cycle in both cases.
  - fill_start in WAIT_VS or FILL is ignored.
  - If fill_start and a request are valid in the same cycle in IDLE, the request is still accepted that cycle.
- WAIT_VS -> FILL on vs_edge.
- FILL:
  - Address counter 0..C_VRAM_LENGTH-1, one write per cycle, `data_din = fill_color`.
  - After address C_VRAM_LENGTH-1 is written: return to IDLE, clear `fill_busy`, pulse `fill_done`.
- Offsets:
  - offset_set loads the staging registers and sets `pending`.
  - On vs_edge with `pending` set: commit staging to the outputs and clear `pending`.
  - offset_set in the same cycle as vs_edge commits the new inputs directly; `pending` ends clear.
  - Repeated offset_set before an edge: the last value wins.
- frame_count increments on every vs_edge and wraps 0xFFFF -> 0.
- Reset mid-fill aborts the fill. There is no fill_done pulse.

## Timing
- Request accept at cycle N -> `data_we` / `data_address` / `data_din` valid at N+1, held for 1 cycle.
- Back-to-back accepts give one write per cycle.
- fill_start at N (`fill_sync = 0`):
  - First fill write on the outputs at N+2.
  - Last write at N+1+C_VRAM_LENGTH.
  - `fill_done` and `fill_busy` falling at N+2+C_VRAM_LENGTH.
  - Readies return to combinational grant once the state is IDLE.
- vsync falls at N -> vs_edge at N -> offset outputs and frame_count updated at N+1. A deferred fill writes address 0 at N+2.

## Structure
- Shared package `vga_pkg` holds the VRAM geometry constants (C_ADDR_WIDTH, C_VRAM_LENGTH, C_OFFSET_WIDTH) and the state encoding (IDLE, WAIT_VS, FILL), shared with `vga_vram_8`.
- One natural sub-module: `rr_arbiter2`, the two-input round-robin grant with pointer update on accept. The FSM, fill counter, offset staging and edge detect stay in the top.

## Test plan
- Req0 only, address 0x123, data 0xA5 -> `data_we` 1 cycle later with address 0x123 and din 0xA5. Req1_ready stays 0 throughout.
- Both valid for 4 cycles -> grants alternate req0, req1, req0, req1. Four consecutive writes, one per cycle.
- fill_start, fill_sync=0, color 0x1C -> 4096 writes covering addresses 0..4095 with 0x1C. Readies 0 for the whole fill. `fill_done` pulses once, 4098 cycles after the start.
- fill_start, fill_sync=1; vsync falls 100 cycles later -> no fill writes before the edge; address 0 written at edge+2. Requests are accepted while in WAIT_VS.
- offset_set h=5, v=7, then h=9, v=3 before the edge -> outputs stay 0 until the edge, then read 9/3 and frame_count=1. offset_set coincident with an edge -> those values appear at edge+1.
- Reset asserted at fill address 2000 -> `data_we` 0 and `fill_busy` 0 next cycle, no `fill_done`. A new fill then starts from address 0.

Source files
------------

// File: rtl/vga_pkg.sv
// VGA VRAM shared geometry constants and write-scheduler state encoding.
// Imported by the VRAM write scheduler and the VRAM model.
package vga_pkg;

  localparam int VGA_ADDR_WIDTH   = 12;
  localparam int VGA_VRAM_LENGTH  = 4096;
  localparam int VGA_OFFSET_WIDTH = 10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_VS = 2'd1,
    ST_FILL    = 2'd2
  } wr_state_e;

endpackage

// File: rtl/vga_vram_write_scheduler_rr_arbiter2.sv
// Two-input round-robin grant; pointer moves only on an accepted transfer.
// Ports: clk/reset, en gates both grants, valid0/1 in, ready0/1 out (comb).
module rr_arbiter2 (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic valid0,
  input  logic valid1,
  output logic ready0,
  output logic ready1
);

  // prio_q = 0 favours requester 0, 1 favours requester 1
  logic prio_q;
  logic prio_d;

  always_comb begin
    ready0 = en & valid0 & (~valid1 | ~prio_q);
    ready1 = en & valid1 & (~valid0 | prio_q);
    prio_d = prio_q;
    unique case (1'b1)
      ready0:  prio_d = 1'b1;
      ready1:  prio_d = 1'b0;
      default: prio_d = prio_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/vga_vram_write_scheduler.sv
// VRAM write-port owner: RR arbiter, clear/fill engine, vblank offset commit.
// Ports: req0/1 valid/ready/addr/data, fill_*, offset_*, data_* and frame_count.
module vga_vram_write_scheduler
  import vga_pkg::*;
#(
  parameter int C_ADDR_WIDTH   = VGA_ADDR_WIDTH,
  parameter int C_VRAM_LENGTH  = VGA_VRAM_LENGTH,
  parameter int C_OFFSET_WIDTH = VGA_OFFSET_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      vsync,
  input  logic                      req0_valid,
  output logic                      req0_ready,
  input  logic [C_ADDR_WIDTH-1:0]   req0_address,
  input  logic [7:0]                req0_data,
  input  logic                      req1_valid,
  output logic                      req1_ready,
  input  logic [C_ADDR_WIDTH-1:0]   req1_address,
  input  logic [7:0]                req1_data,
  input  logic                      fill_start,
  input  logic                      fill_sync,
  input  logic [7:0]                fill_color,
  output logic                      fill_busy,
  output logic                      fill_done,
  input  logic                      offset_set,
  input  logic [C_OFFSET_WIDTH-1:0] offset_h_in,
  input  logic [C_OFFSET_WIDTH-1:0] offset_v_in,
  output logic [31:0]               data_address,
  output logic [7:0]                data_din,
  output logic                      data_we,
  output logic [31:0]               offset_h,
  output logic [31:0]               offset_v,
  output logic [15:0]               frame_count
);

  localparam logic [C_ADDR_WIDTH-1:0] LAST_ADDR =
    C_ADDR_WIDTH'(C_VRAM_LENGTH - 1);

  wr_state_e state_q, state_d;

  logic [C_ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [7:0]              color_q, color_d;
  logic                    busy_q, busy_d;
  logic                    last_q, last_d;
  logic                    done_q, done_d;

  logic [31:0] addr_q, addr_d;
  logic [7:0]  din_q, din_d;
  logic        we_q, we_d;

  logic                      vsync_d_q;
  logic                      vs_edge;
  logic                      pend_q, pend_d;
  logic [C_OFFSET_WIDTH-1:0] stage_h_q, stage_h_d;
  logic [C_OFFSET_WIDTH-1:0] stage_v_q, stage_v_d;
  logic [C_OFFSET_WIDTH-1:0] off_h_q, off_h_d;
  logic [C_OFFSET_WIDTH-1:0] off_v_q, off_v_d;
  logic [15:0]               fc_q, fc_d;

  logic arb_en;
  logic rdy0;
  logic rdy1;
  logic start_ok;

  assign vs_edge  = vsync_d_q & ~vsync;
  assign arb_en   = (state_q != ST_FILL);
  assign start_ok = fill_start & (state_q == ST_IDLE);

  rr_arbiter2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .en     (arb_en),
    .valid0 (req0_valid),
    .valid1 (req1_valid),
    .ready0 (rdy0),
    .ready1 (rdy1)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    color_d = color_q;
    last_d  = 1'b0;
    we_d    = 1'b0;
    addr_d  = addr_q;
    din_d   = din_q;
    unique case (state_q)
      ST_IDLE: begin
        if (fill_start) begin
          color_d = fill_color;
          cnt_d   = '0;
          state_d = fill_sync ? ST_WAIT_VS : ST_FILL;
        end
      end
      ST_WAIT_VS: begin
        if (vs_edge) state_d = ST_FILL;
      end
      ST_FILL: begin
        we_d   = 1'b1;
        addr_d = 32'(cnt_q);
        din_d  = color_q;
        if (cnt_q == LAST_ADDR) begin
          state_d = ST_IDLE;
          last_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // grants are already zero in FILL, so this never collides with the engine
    unique case (1'b1)
      rdy0: begin
        we_d   = 1'b1;
        addr_d = 32'(req0_address);
        din_d  = req0_data;
      end
      rdy1: begin
        we_d   = 1'b1;
        addr_d = 32'(req1_address);
        din_d  = req1_data;
      end
      default: ;
    endcase
    // done/busy trail the last write by one cycle so they line up
    // with the write appearing on the port
    busy_d = start_ok | (busy_q & ~last_q);
    done_d = last_q;
  end

  always_comb begin
    stage_h_d = stage_h_q;
    stage_v_d = stage_v_q;
    pend_d    = pend_q;
    off_h_d   = off_h_q;
    off_v_d   = off_v_q;
    fc_d      = fc_q;
    if (offset_set) begin
      stage_h_d = offset_h_in;
      stage_v_d = offset_v_in;
      pend_d    = 1'b1;
    end
    if (vs_edge) begin
      fc_d = fc_q + 16'd1;
      if (offset_set) begin
        off_h_d = offset_h_in;
        off_v_d = offset_v_in;
        pend_d  = 1'b0;
      end else if (pend_q) begin
        off_h_d = stage_h_q;
        off_v_d = stage_v_q;
        pend_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      color_q   <= '0;
      busy_q    <= 1'b0;
      last_q    <= 1'b0;
      done_q    <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      din_q     <= '0;
      vsync_d_q <= 1'b1;
      pend_q    <= 1'b0;
      stage_h_q <= '0;
      stage_v_q <= '0;
      off_h_q   <= '0;
      off_v_q   <= '0;
      fc_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      color_q   <= color_d;
      busy_q    <= busy_d;
      last_q    <= last_d;
      done_q    <= done_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
      vsync_d_q <= vsync;
      pend_q    <= pend_d;
      stage_h_q <= stage_h_d;
      stage_v_q <= stage_v_d;
      off_h_q   <= off_h_d;
      off_v_q   <= off_v_d;
      fc_q      <= fc_d;
    end
  end

  assign req0_ready   = rdy0;
  assign req1_ready   = rdy1;
  assign fill_busy    = busy_q;
  assign fill_done    = done_q;
  assign data_address = addr_q;
  assign data_din     = din_q;
  assign data_we      = we_q;
  assign offset_h     = 32'(off_h_q);
  assign offset_v     = 32'(off_v_q);
  assign frame_count  = fc_q;

endmodule

// File: tb/tb_vga_vram_write_scheduler.sv
// Directed bench for vga_vram_write_scheduler.
// Drives and samples on the falling clock edge.
module tb_vga_vram_write_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        vsync;
  logic        req0_valid, req0_ready;
  logic [11:0] req0_address;
  logic [7:0]  req0_data;
  logic        req1_valid, req1_ready;
  logic [11:0] req1_address;
  logic [7:0]  req1_data;
  logic        fill_start, fill_sync;
  logic [7:0]  fill_color;
  logic        fill_busy, fill_done;
  logic        offset_set;
  logic [9:0]  offset_h_in, offset_v_in;
  logic [31:0] data_address;
  logic [7:0]  data_din;
  logic        data_we;
  logic [31:0] offset_h, offset_v;
  logic [15:0] frame_count;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  vga_vram_write_scheduler dut (
    .clk          (clk),
    .reset        (reset),
    .vsync        (vsync),
    .req0_valid   (req0_valid),
    .req0_ready   (req0_ready),
    .req0_address (req0_address),
    .req0_data    (req0_data),
    .req1_valid   (req1_valid),
    .req1_ready   (req1_ready),
    .req1_address (req1_address),
    .req1_data    (req1_data),
    .fill_start   (fill_start),
    .fill_sync    (fill_sync),
    .fill_color   (fill_color),
    .fill_busy    (fill_busy),
    .fill_done    (fill_done),
    .offset_set   (offset_set),
    .offset_h_in  (offset_h_in),
    .offset_v_in  (offset_v_in),
    .data_address (data_address),
    .data_din     (data_din),
    .data_we      (data_we),
    .offset_h     (offset_h),
    .offset_v     (offset_v),
    .frame_count  (frame_count)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int lim);
    int k;
    k = 0;
    while (fill_done !== 1'b1 && k < lim) begin
      step();
      k++;
    end
    chk(tag, 32'(k < lim), 32'd1);
  endtask

  initial begin
    int bad_w, bad_r, bad_d;
    reset = 1'b1;
    vsync = 1'b1;
    req0_valid = 0; req0_address = '0; req0_data = '0;
    req1_valid = 0; req1_address = '0; req1_data = '0;
    fill_start = 0; fill_sync = 0; fill_color = '0;
    offset_set = 0; offset_h_in = '0; offset_v_in = '0;
    step();
    do_reset();

    // reset state
    chk("rst_we", 32'(data_we), 0);
    chk("rst_addr", data_address, 0);
    chk("rst_busy", 32'(fill_busy), 0);
    chk("rst_done", 32'(fill_done), 0);
    chk("rst_offh", offset_h, 0);
    chk("rst_offv", offset_v, 0);
    chk("rst_fc", 32'(frame_count), 0);

    // single request on req0
    req0_valid = 1; req0_address = 12'h123; req0_data = 8'hA5;
    #1;
    chk("r0_rdy0", 32'(req0_ready), 1);
    chk("r0_rdy1", 32'(req1_ready), 0);
    step();
    req0_valid = 0;
    chk("r0_we", 32'(data_we), 1);
    chk("r0_addr", data_address, 32'h123);
    chk("r0_din", 32'(data_din), 32'hA5);
    chk("r0_rdy1b", 32'(req1_ready), 0);
    step();
    chk("r0_we_off", 32'(data_we), 0);

    // round robin from a fresh pointer
    do_reset();
    req0_address = 12'h010; req0_data = 8'h11;
    req1_address = 12'h020; req1_data = 8'h22;
    req0_valid = 1; req1_valid = 1;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin req0_valid = 0; req1_valid = 0; end
      #1;
      if (i < 4) begin
        chk($sformatf("rr_rdy0_%0d", i), 32'(req0_ready), 32'(i % 2 == 0));
        chk($sformatf("rr_rdy1_%0d", i), 32'(req1_ready), 32'(i % 2 == 1));
      end
      if (i > 0) begin
        chk($sformatf("rr_we_%0d", i - 1), 32'(data_we), 1);
        chk($sformatf("rr_addr_%0d", i - 1), data_address,
            ((i - 1) % 2 == 0) ? 32'h010 : 32'h020);
      end
      step();
    end
    chk("rr_we_off", 32'(data_we), 0);

    // immediate fill, start at cycle N
    fill_start = 1; fill_sync = 0; fill_color = 8'h1C;
    step();
    fill_start = 0;
    req0_valid = 1; req1_valid = 1;
    chk("f_busy_n1", 32'(fill_busy), 1);
    chk("f_we_n1", 32'(data_we), 0);
    bad_w = 0; bad_r = 0; bad_d = 0;
    for (int k = 2; k <= 4097; k++) begin
      step();
      #1;
      if (data_we !== 1'b1 || data_address !== 32'(k - 2) ||
          data_din !== 8'h1C)
        bad_w++;
      if (k <= 4096 && (req0_ready !== 1'b0 || req1_ready !== 1'b0))
        bad_r++;
      if (fill_done !== 1'b0 || fill_busy !== 1'b1) bad_d++;
      if (k == 4096) begin req0_valid = 0; req1_valid = 0; end
    end
    chk("f_writes", 32'(bad_w), 0);
    chk("f_readies", 32'(bad_r), 0);
    chk("f_busy_run", 32'(bad_d), 0);
    step();
    chk("f_done", 32'(fill_done), 1);
    chk("f_busy_end", 32'(fill_busy), 0);
    chk("f_we_end", 32'(data_we), 0);
    step();
    chk("f_done_1cyc", 32'(fill_done), 0);

    // deferred fill
    fill_start = 1; fill_sync = 1; fill_color = 8'h3C;
    step();
    fill_start = 0;
    chk("d_busy", 32'(fill_busy), 1);
    req1_valid = 1; req1_address = 12'h0AB; req1_data = 8'h77;
    #1;
    chk("d_rdy1", 32'(req1_ready), 1);
    step();
    req1_valid = 0;
    chk("d_req_we", 32'(data_we), 1);
    chk("d_req_addr", data_address, 32'h0AB);
    bad_w = 0;
    for (int k = 0; k < 98; k++) begin
      step();
      if (data_we !== 1'b0) bad_w++;
    end
    chk("d_no_early", 32'(bad_w), 0);
    vsync = 0;
    step();
    chk("d_we_e1", 32'(data_we), 0);
    chk("d_fc_e1", 32'(frame_count), 1);
    step();
    vsync = 1;
    chk("d_we_e2", 32'(data_we), 1);
    chk("d_addr_e2", data_address, 0);
    chk("d_din_e2", 32'(data_din), 32'h3C);
    wait_done("d_done", 5000);

    // offset staging
    do_reset();
    offset_set = 1; offset_h_in = 10'd5; offset_v_in = 10'd7;
    step();
    offset_h_in = 10'd9; offset_v_in = 10'd3;
    step();
    offset_set = 0;
    chk("o_h_pre", offset_h, 0);
    chk("o_v_pre", offset_v, 0);
    for (int k = 0; k < 5; k++) step();
    chk("o_h_pre2", offset_h, 0);
    vsync = 0;
    step();
    vsync = 1;
    chk("o_h_edge", offset_h, 9);
    chk("o_v_edge", offset_v, 3);
    chk("o_fc_edge", 32'(frame_count), 1);
    step();
    step();
    vsync = 0; offset_set = 1;
    offset_h_in = 10'h3FF; offset_v_in = 10'h155;
    step();
    vsync = 1; offset_set = 0;
    chk("o_h_coin", offset_h, 32'h3FF);
    chk("o_v_coin", offset_v, 32'h155);
    chk("o_fc_coin", 32'(frame_count), 2);
    step();
    vsync = 0;
    step();
    vsync = 1;
    chk("o_h_hold", offset_h, 32'h3FF);
    chk("o_fc_3", 32'(frame_count), 3);

    // reset in the middle of a fill
    fill_start = 1; fill_sync = 0; fill_color = 8'h44;
    step();
    fill_start = 0;
    for (int k = 2; k <= 2002; k++) step();
    chk("rm_addr", data_address, 32'd2000);
    reset = 1;
    step();
    chk("rm_we", 32'(data_we), 0);
    chk("rm_busy", 32'(fill_busy), 0);
    reset = 0;
    bad_d = 0;
    for (int k = 0; k < 8; k++) begin
      if (fill_done !== 1'b0 || data_we !== 1'b0) bad_d++;
      step();
    end
    chk("rm_quiet", 32'(bad_d), 0);
    fill_start = 1; fill_sync = 0; fill_color = 8'h55;
    step();
    fill_start = 0;
    step();
    chk("rm2_we", 32'(data_we), 1);
    chk("rm2_addr", data_address, 0);
    chk("rm2_din", 32'(data_din), 32'h55);
    wait_done("rm2_done", 5000);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
